vx_smem_ext_bridge: RTL

//  Per-lane bridge between the shared-memory request path of a core's LSU/dcache switch and an

---
 rtl/vx_smem_ext_bridge.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/vx_smem_ext_bridge.sv
// vx_smem_ext_bridge
// Per-lane bridge from the core shared-memory request path to an external
// TileLink-UL style A/D channel pair. Each accepted request takes a source ID
// that it keeps until its D beat returns. Write acks are dropped. Read data is
// queued in a 2-entry response FIFO together with the original request tag.
module vx_smem_ext_bridge #(
    parameter int WORD_SIZE  = 4,
    parameter int ADDR_WIDTH = 30,
    parameter int TAG_WIDTH  = 8,
    parameter int NUM_SRC    = 4,
    localparam int SRC_WIDTH   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int DATA_W      = WORD_SIZE * 8,
    localparam int OFF_W       = $clog2(WORD_SIZE),
    localparam int BYTE_ADDR_W = ADDR_WIDTH + OFF_W
) (
    input  logic                   clk,
    input  logic                   reset_n,

    input  logic                   req_valid,
    input  logic                   req_rw,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [WORD_SIZE-1:0]   req_byteen,
    input  logic [DATA_W-1:0]      req_data,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic                   req_ready,

    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    input  logic                   rsp_ready,

    output logic                   a_valid,
    input  logic                   a_ready,
    output logic [2:0]             a_opcode,
    output logic [SRC_WIDTH-1:0]   a_source,
    output logic [BYTE_ADDR_W-1:0] a_address,
    output logic [WORD_SIZE-1:0]   a_mask,
    output logic [DATA_W-1:0]      a_data,

    input  logic                   d_valid,
    output logic                   d_ready,
    input  logic [2:0]             d_opcode,
    input  logic [SRC_WIDTH-1:0]   d_source,
    input  logic [DATA_W-1:0]      d_data,

    output logic                   busy
);

    localparam logic [2:0] OP_GET        = 3'd4;
    localparam logic [2:0] OP_PUT_FULL   = 3'd0;
    localparam logic [2:0] OP_PUT_PART   = 3'd1;
    localparam logic [2:0] OP_ACK        = 3'd0;
    localparam logic [2:0] OP_ACK_DATA   = 3'd1;

    // Source ID bookkeeping: free mask plus per-ID record of the originating request.
    logic [NUM_SRC-1:0]   free;
    logic [TAG_WIDTH-1:0] table_tag [NUM_SRC];
    logic [NUM_SRC-1:0]   table_rw;

    logic                 any_free;
    logic [SRC_WIDTH-1:0] alloc_src;
    logic                 a_fire;
    logic                 d_fire;

    // Response FIFO (2 entries) state.
    logic [DATA_W-1:0]    fifo_data [2];
    logic [TAG_WIDTH-1:0] fifo_tag  [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic                 fifo_full;
    logic                 fifo_push;
    logic                 fifo_pop;

    assign any_free  = |free;
    assign busy      = ~&free;

    // A channel is a direct combinational pass of the request, gated by ID availability.
    assign a_valid   = req_valid & any_free;
    assign req_ready = a_ready & any_free;
    assign a_fire    = req_valid & req_ready;
    assign a_source  = alloc_src;
    assign a_address = BYTE_ADDR_W'(req_addr) << OFF_W;
    assign a_mask    = req_rw ? req_byteen : {WORD_SIZE{1'b1}};
    assign a_data    = req_data;

    // Opcode selection: reads are Get, full-mask writes PutFull, others PutPartial.
    always_comb begin
        a_opcode = OP_GET;
        if (req_rw) begin
            a_opcode = (&req_byteen) ? OP_PUT_FULL : OP_PUT_PART;
        end
    end

    // Lowest-index free source ID (scan high to low so the lowest wins).
    always_comb begin
        alloc_src = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (free[i]) begin
                alloc_src = SRC_WIDTH'(i);
            end
        end
    end

    // D channel: accept whenever the FIFO has room; only read data is queued.
    assign fifo_full = (count == 2'd2);
    assign d_ready   = ~fifo_full;
    assign d_fire    = d_valid & d_ready;
    assign fifo_push = d_fire & ~table_rw[d_source];
    assign fifo_pop  = rsp_valid & rsp_ready;

    assign rsp_valid = (count != 2'd0);
    assign rsp_data  = fifo_data[rd_ptr];
    assign rsp_tag   = fifo_tag[rd_ptr];

    // Free mask: allocate on A fire, release on D fire. The two never hit the same
    // ID in one cycle because allocation only picks IDs that are already free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            free <= '1;
        end else begin
            if (a_fire) begin
                free[alloc_src] <= 1'b0;
            end
            if (d_fire) begin
                free[d_source] <= 1'b1;
            end
        end
    end

    // Record tag and direction of each issued request under its source ID.
    always_ff @(posedge clk) begin
        if (a_fire) begin
            table_tag[alloc_src] <= req_tag;
            table_rw[alloc_src]  <= req_rw;
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (fifo_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Response FIFO storage: read data paired with the tag of the originating read.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data[wr_ptr] <= d_data;
            fifo_tag[wr_ptr]  <= table_tag[d_source];
        end
    end

`ifndef SYNTHESIS
    // A D beat must refer to an ID that is currently outstanding.
    a_d_src_busy: assert property (@(posedge clk) disable iff (!reset_n)
        d_fire |-> !free[d_source]);

    // D opcode must agree with the direction recorded for that ID.
    a_d_opcode_match: assert property (@(posedge clk) disable iff (!reset_n)
        d_fire |-> (d_opcode == (table_rw[d_source] ? OP_ACK : OP_ACK_DATA)));

    // A stalled request must be held stable until accepted.
    a_req_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (req_valid && !req_ready) |=> (req_valid &&
            $stable({req_rw, req_addr, req_byteen, req_data, req_tag})));
`endif

endmodule
